// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flushes, data-memory wait freeze.
// Optional macro HAZARD_STALL_COUNT_EN adds the StallCount output (cycles with PCWrite low).
module hazard_stall_controller_chk (
  input logic       clk,
  input logic       reset,
  input logic       PCWrite,
  input logic       ID_EX_Bubble,
  input logic       ID_EX_Flush,
  input logic       EX_MEM_Hold,
  input logic [1:0] State
);

  a_bubble_vs_flush: assert property (@(posedge clk) disable iff (!reset)
    !(ID_EX_Bubble && ID_EX_Flush));

  a_pc_vs_hold: assert property (@(posedge clk) disable iff (!reset)
    !(PCWrite && EX_MEM_Hold));

  a_state_legal: assert property (@(posedge clk) disable iff (!reset)
    State != 2'b10);

endmodule

module hazard_stall_controller #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MAX_MEM_WAIT      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rt,
  input  logic       EX_BranchTaken,
  input  logic       MEM_Req,
  input  logic       MEM_Ready,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       EX_MEM_Hold,
  output logic       MemTimeout,
  output logic [1:0] State
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [15:0] StallCount
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_LOAD_STALL = 2'b01,
    ST_UNUSED     = 2'b10,
    ST_MEM_WAIT   = 2'b11
  } state_e;

  localparam logic [1:0] STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_MEM_WAIT);

  state_e     state_q, state_d;
  logic [1:0] rem_q, rem_d;
  logic       ret_ls_q, ret_ls_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;

  logic       lu_s;
  logic       ms_s;
  logic [7:0] wait_inc_s;
  logic       pcw_s;
  logic       ifw_s;
  logic       bubble_s;
  logic       if_flush_s;
  logic       ex_flush_s;
  logic       hold_s;

  assign lu_s = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                ((ID_EX_Rt == ID_Rs) || (ID_UsesRt && (ID_EX_Rt == ID_Rt)));
  assign ms_s = MEM_Req && !MEM_Ready;
  assign wait_inc_s = (wait_q == 8'hFF) ? 8'hFF : (wait_q + 8'd1);

  // Next-state and stage-control decode; memory stall outranks everything.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    ret_ls_d   = ret_ls_q;
    wait_d     = wait_q;
    timeout_d  = timeout_q;
    pcw_s      = 1'b0;
    ifw_s      = 1'b0;
    bubble_s   = 1'b0;
    if_flush_s = 1'b0;
    ex_flush_s = 1'b0;
    hold_s     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ms_s) begin
          hold_s   = 1'b1;
          state_d  = ST_MEM_WAIT;
          ret_ls_d = 1'b0;
          wait_d   = 8'd0;
        end else if (EX_BranchTaken) begin
          pcw_s      = 1'b1;
          ifw_s      = 1'b1;
          if_flush_s = 1'b1;
          ex_flush_s = 1'b1;
        end else if (lu_s) begin
          bubble_s = 1'b1;
          if (STALL_INIT != 2'd0) begin
            state_d = ST_LOAD_STALL;
            rem_d   = STALL_INIT;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          pcw_s = 1'b1;
          ifw_s = 1'b1;
        end
      end
      ST_LOAD_STALL: begin
        if (ms_s) begin
          hold_s   = 1'b1;
          state_d  = ST_MEM_WAIT;
          ret_ls_d = 1'b1;
          wait_d   = 8'd0;
        end else begin
          bubble_s = 1'b1;
          rem_d    = rem_q - 2'd1;
          if (rem_q <= 2'd1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LOAD_STALL;
          end
        end
      end
      ST_MEM_WAIT: begin
        // Only MEM_Ready releases the freeze, even after a timeout.
        if (MEM_Ready) begin
          pcw_s   = 1'b1;
          ifw_s   = 1'b1;
          wait_d  = 8'd0;
          if (ret_ls_q) begin
            state_d = ST_LOAD_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          hold_s = 1'b1;
          wait_d = wait_inc_s;
          if (wait_inc_s == WAIT_LIMIT) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
        end
      end
      default: begin
        state_d  = ST_RUN;
        rem_d    = 2'd0;
        ret_ls_d = 1'b0;
        wait_d   = 8'd0;
      end
    endcase
  end

  // State, counters and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      rem_q     <= 2'd0;
      ret_ls_q  <= 1'b0;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      ret_ls_q  <= ret_ls_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Controls are decoded in-cycle; reset masks them asynchronously.
  assign PCWrite      = reset & pcw_s;
  assign IF_ID_Write  = reset & ifw_s;
  assign ID_EX_Bubble = reset & bubble_s;
  assign IF_ID_Flush  = reset & if_flush_s;
  assign ID_EX_Flush  = reset & ex_flush_s;
  assign EX_MEM_Hold  = reset & hold_s;
  assign MemTimeout   = timeout_q;
  assign State        = state_q;

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
    end else if (!pcw_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign StallCount = stall_cnt_q;
`endif

  hazard_stall_controller_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .ID_EX_Bubble(ID_EX_Bubble),
    .ID_EX_Flush (ID_EX_Flush),
    .EX_MEM_Hold (EX_MEM_Hold),
    .State       (State)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: one DUT with LOAD_STALL_CYCLES=1, one with 3.
module tb_hazard_stall_controller;

  // Packed view: {PCWrite, IF_ID_Write, Bubble, IF_ID_Flush, ID_EX_Flush, Hold, MemTimeout, State}
  localparam logic [8:0] O_RESET     = 9'b0_0_0_0_0_0_0_00;
  localparam logic [8:0] O_RUN       = 9'b1_1_0_0_0_0_0_00;
  localparam logic [8:0] O_RUN_TO    = 9'b1_1_0_0_0_0_1_00;
  localparam logic [8:0] O_BUB_RUN   = 9'b0_0_1_0_0_0_0_00;
  localparam logic [8:0] O_BUB_LS    = 9'b0_0_1_0_0_0_0_01;
  localparam logic [8:0] O_BR        = 9'b1_1_0_1_1_0_0_00;
  localparam logic [8:0] O_HOLD_RUN  = 9'b0_0_0_0_0_1_0_00;
  localparam logic [8:0] O_HOLD_LS   = 9'b0_0_0_0_0_1_0_01;
  localparam logic [8:0] O_HOLD_MW   = 9'b0_0_0_0_0_1_0_11;
  localparam logic [8:0] O_HOLD_MWTO = 9'b0_0_0_0_0_1_1_11;
  localparam logic [8:0] O_REL_MW    = 9'b1_1_0_0_0_0_0_11;
  localparam logic [8:0] O_REL_MWTO  = 9'b1_1_0_0_0_0_1_11;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       uses_rt, ex_memread, br_taken, mem_req, mem_ready;

  logic       pcw1, ifw1, bub1, iff1, exf1, hold1, to1;
  logic [1:0] st1;
  logic       pcw3, ifw3, bub3, iff3, exf3, hold3, to3;
  logic [1:0] st3;
`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] sc1, sc3;
`endif

  logic [8:0] o1, o3, exp_v;
  assign o1 = {pcw1, ifw1, bub1, iff1, exf1, hold1, to1, st1};
  assign o3 = {pcw3, ifw3, bub3, iff3, exf3, hold3, to3, st3};

  int n_checks = 0;
  int n_fail   = 0;

  hazard_stall_controller #(.LOAD_STALL_CYCLES(1), .MAX_MEM_WAIT(15)) u_dut1 (
    .clk(clk), .reset(reset), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(uses_rt),
    .ID_EX_MemRead(ex_memread), .ID_EX_Rt(ex_rt), .EX_BranchTaken(br_taken),
    .MEM_Req(mem_req), .MEM_Ready(mem_ready), .PCWrite(pcw1), .IF_ID_Write(ifw1),
    .ID_EX_Bubble(bub1), .IF_ID_Flush(iff1), .ID_EX_Flush(exf1), .EX_MEM_Hold(hold1),
    .MemTimeout(to1), .State(st1)
`ifdef HAZARD_STALL_COUNT_EN
    , .StallCount(sc1)
`endif
  );

  hazard_stall_controller #(.LOAD_STALL_CYCLES(3), .MAX_MEM_WAIT(15)) u_dut3 (
    .clk(clk), .reset(reset), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(uses_rt),
    .ID_EX_MemRead(ex_memread), .ID_EX_Rt(ex_rt), .EX_BranchTaken(br_taken),
    .MEM_Req(mem_req), .MEM_Ready(mem_ready), .PCWrite(pcw3), .IF_ID_Write(ifw3),
    .ID_EX_Bubble(bub3), .IF_ID_Flush(iff3), .ID_EX_Flush(exf3), .EX_MEM_Hold(hold3),
    .MemTimeout(to3), .State(st3)
`ifdef HAZARD_STALL_COUNT_EN
    , .StallCount(sc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; uses_rt = 1'b0;
    ex_memread = 1'b0; br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    br_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    reset = 1'b0;
    next_cycle();
    n_checks++;
    if (o1 !== O_RESET) begin n_fail++; $display("FAIL reset_dut1: got %b expected %b", o1, O_RESET); end
    n_checks++;
    if (o3 !== O_RESET) begin n_fail++; $display("FAIL reset_dut3: got %b expected %b", o3, O_RESET); end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (o1 !== O_RUN) begin n_fail++; $display("FAIL reset_release_run: got %b expected %b", o1, O_RUN); end
    next_cycle();
  endtask

  task automatic test_hazard_detect();
    apply_reset();
    // Rt=0 never hazards
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    @(negedge clk);
    n_checks++;
    if (o1 !== O_RUN) begin n_fail++; $display("FAIL lu_r0: got %b expected %b", o1, O_RUN); end
    next_cycle();
    // Rt match without ID_UsesRt
    ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; uses_rt = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o1 !== O_RUN) begin n_fail++; $display("FAIL lu_rt_unused: got %b expected %b", o1, O_RUN); end
    next_cycle();
    uses_rt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o1 !== O_BUB_RUN) begin n_fail++; $display("FAIL lu_rt_used: got %b expected %b", o1, O_BUB_RUN); end
    next_cycle();
    idle_inputs();
    mem_req = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o1 !== O_RUN) begin n_fail++; $display("FAIL mem_ready_nostall: got %b expected %b", o1, O_RUN); end
    next_cycle();
  endtask

  task automatic test_load_use_1();
    apply_reset();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    n_checks++;
    if (o1 !== O_BUB_RUN) begin n_fail++; $display("FAIL lu1_bubble: got %b expected %b", o1, O_BUB_RUN); end
    next_cycle();
    ex_memread = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o1 !== O_RUN) begin n_fail++; $display("FAIL lu1_resume: got %b expected %b", o1, O_RUN); end
    next_cycle();
  endtask

  task automatic test_load_use_3();
    apply_reset();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    n_checks++;
    if (o3 !== O_BUB_RUN) begin n_fail++; $display("FAIL lu3_bub1: got %b expected %b", o3, O_BUB_RUN); end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (o3 !== O_BUB_LS) begin n_fail++; $display("FAIL lu3_bub2: got %b expected %b", o3, O_BUB_LS); end
    next_cycle();
    br_taken = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o3 !== O_BUB_LS) begin n_fail++; $display("FAIL lu3_bub3_branch_ignored: got %b expected %b", o3, O_BUB_LS); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (o3 !== O_RUN) begin n_fail++; $display("FAIL lu3_resume: got %b expected %b", o3, O_RUN); end
    next_cycle();
  endtask

  task automatic test_branch();
    apply_reset();
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; uses_rt = 1'b1; id_rs = 5'd3; br_taken = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o1 !== O_BR) begin n_fail++; $display("FAIL branch_lu_dut1: got %b expected %b", o1, O_BR); end
    n_checks++;
    if (o3 !== O_BR) begin n_fail++; $display("FAIL branch_lu_dut3: got %b expected %b", o3, O_BR); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (o3 !== O_RUN) begin n_fail++; $display("FAIL branch_after: got %b expected %b", o3, O_RUN); end
    next_cycle();
  endtask

  task automatic test_mem_timeout();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0; br_taken = 1'b1;
    ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    @(negedge clk);
    n_checks++;
    if (o1 !== O_HOLD_RUN) begin n_fail++; $display("FAIL ms_priority: got %b expected %b", o1, O_HOLD_RUN); end
    next_cycle();
    br_taken = 1'b0; ex_memread = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      exp_v = (k >= 16) ? O_HOLD_MWTO : O_HOLD_MW;
      n_checks++;
      if (o1 !== exp_v) begin n_fail++; $display("FAIL mem_wait_cycle_%0d: got %b expected %b", k, o1, exp_v); end
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o1 !== O_REL_MWTO) begin n_fail++; $display("FAIL mem_release: got %b expected %b", o1, O_REL_MWTO); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (o1 !== O_RUN_TO) begin n_fail++; $display("FAIL timeout_sticky1: got %b expected %b", o1, O_RUN_TO); end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (o1 !== O_RUN_TO) begin n_fail++; $display("FAIL timeout_sticky2: got %b expected %b", o1, O_RUN_TO); end
    next_cycle();
  endtask

  task automatic test_ms_in_load_stall();
    apply_reset();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    n_checks++;
    if (o3 !== O_BUB_RUN) begin n_fail++; $display("FAIL msls_bub1: got %b expected %b", o3, O_BUB_RUN); end
    next_cycle();
    ex_memread = 1'b0; mem_req = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o3 !== O_HOLD_LS) begin n_fail++; $display("FAIL msls_hold_ls: got %b expected %b", o3, O_HOLD_LS); end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (o3 !== O_HOLD_MW) begin n_fail++; $display("FAIL msls_wait_%0d: got %b expected %b", k, o3, O_HOLD_MW); end
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o3 !== O_REL_MW) begin n_fail++; $display("FAIL msls_release: got %b expected %b", o3, O_REL_MW); end
    next_cycle();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (o3 !== O_BUB_LS) begin n_fail++; $display("FAIL msls_resume_bub_%0d: got %b expected %b", k, o3, O_BUB_LS); end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (o3 !== O_RUN) begin n_fail++; $display("FAIL msls_back_run: got %b expected %b", o3, O_RUN); end
    next_cycle();
  endtask

  task automatic test_reset_mid_state();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < 17; k++) next_cycle();
    n_checks++;
    if (o1 !== O_HOLD_MWTO) begin n_fail++; $display("FAIL rst_pre_wait: got %b expected %b", o1, O_HOLD_MWTO); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (o1 !== O_RESET) begin n_fail++; $display("FAIL rst_mid_wait: got %b expected %b", o1, O_RESET); end
`ifdef HAZARD_STALL_COUNT_EN
    n_checks++;
    if (sc1 !== 16'd0) begin n_fail++; $display("FAIL rst_stallcount: got %0d expected 0", sc1); end
`endif
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (o1 !== O_RUN) begin n_fail++; $display("FAIL rst_wait_release: got %b expected %b", o1, O_RUN); end
    next_cycle();
    // mid-LOAD_STALL on the 3-cycle instance
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    next_cycle();
    n_checks++;
    if (o3 !== O_BUB_LS) begin n_fail++; $display("FAIL rst_pre_ls: got %b expected %b", o3, O_BUB_LS); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (o3 !== O_RESET) begin n_fail++; $display("FAIL rst_mid_ls: got %b expected %b", o3, O_RESET); end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (o3 !== O_RUN) begin n_fail++; $display("FAIL rst_ls_release: got %b expected %b", o3, O_RUN); end
    next_cycle();
  endtask

`ifdef HAZARD_STALL_COUNT_EN
  task automatic test_stall_count();
    apply_reset();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();
    n_checks++;
    if (sc1 !== 16'd1) begin n_fail++; $display("FAIL stallcount_dut1: got %0d expected 1", sc1); end
    n_checks++;
    if (sc3 !== 16'd3) begin n_fail++; $display("FAIL stallcount_dut3: got %0d expected 3", sc3); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_hazard_detect();
    test_load_use_1();
    test_load_use_3();
    test_branch();
    test_mem_timeout();
    test_ms_in_load_stall();
    test_reset_mid_state();
`ifdef HAZARD_STALL_COUNT_EN
    test_stall_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
